// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port IDs
// and the legal memory-latency range.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; an active lock pins the choice to
// the lock owner, who is granted only when it is actually requesting.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_id    = PORT_C;
        grant_valid = 1'b0;
        if (lock_valid) begin
            grant_id    = lock_owner;
            grant_valid = req[lock_owner];
        end else if (&req) begin
            grant_id    = ~last;
            grant_valid = 1'b1;
        end else if (req[PORT_C]) begin
            grant_id    = PORT_C;
            grant_valid = 1'b1;
        end else if (req[PORT_D]) begin
            grant_id    = PORT_D;
            grant_valid = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialising round-robin arbiter between core port C and debug port D onto a
// single-port memory. Define MEM_ARB_LOCK_EN to honour c_lock/d_lock.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int RESET_PRIO  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              c_lock,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              last;
    logic              grant_id;
    logic              grant_valid;
    logic              pick_lock_valid;
    logic              pick_lock_owner;
    logic              in_busy;

`ifdef MEM_ARB_LOCK_EN
    logic lock_valid;
    logic lock_owner;
    logic lat_lock;

    assign pick_lock_valid = lock_valid;
    assign pick_lock_owner = lock_owner;

    // Lock is recorded at grant and only released by an unlocked access finishing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_valid <= 1'b0;
            lock_owner <= PORT_C;
            lat_lock   <= 1'b0;
        end else if (state == ST_IDLE && grant_valid) begin
            lat_lock <= grant_id ? d_lock : c_lock;
            if (grant_id ? d_lock : c_lock) begin
                lock_valid <= 1'b1;
                lock_owner <= grant_id;
            end
        end else if (state == ST_DONE && !lat_lock) begin
            lock_valid <= 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock     = c_lock ^ d_lock;
    assign pick_lock_valid = 1'b0;
    assign pick_lock_owner = PORT_C;
`endif

    rr_pick2 u_pick (
        .req         ({d_req, c_req}),
        .last        (last),
        .lock_valid  (pick_lock_valid),
        .lock_owner  (pick_lock_owner),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner     <= PORT_C;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last      <= (RESET_PRIO != 0) ? PORT_C : PORT_D;
            c_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (grant_valid) begin
                    owner     <= grant_id;
                    lat_we    <= grant_id ? d_we    : c_we;
                    lat_addr  <= grant_id ? d_addr  : c_addr;
                    lat_wdata <= grant_id ? d_wdata : c_wdata;
                    cnt       <= LAT;
                    state     <= ST_BUSY;
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (!lat_we && owner == PORT_C) c_rdata <= mem_data;
                        if (!lat_we && owner == PORT_D) d_rdata <= mem_data;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last  <= owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_busy        = (state == ST_BUSY);
    assign busy           = (state != ST_IDLE);
    assign c_gnt          = in_busy && owner == PORT_C;
    assign d_gnt          = in_busy && owner == PORT_D;
    assign c_done         = (state == ST_DONE) && owner == PORT_C;
    assign d_done         = (state == ST_DONE) && owner == PORT_D;
    assign mem_addr       = in_busy ? lat_addr  : '0;
    assign mem_write_data = in_busy ? lat_wdata : '0;
    // The counter still holds its load value only in the first BUSY cycle.
    assign mem_write_en   = in_busy && lat_we && cnt == LAT;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses plus
// hand-written reset, round-robin, req-drop and lock sequences.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk, reset;
    logic        c_req, c_we, c_lock, c_gnt, c_done;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_data;
    logic        mem_write_en, busy;

    int          errors = 0;
    int          checks = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] mem[0:63];
    logic [31:0] ref_mem[0:63];
    logic        mem_init = 1'b0;
    vec_t        vt[6];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .RESET_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_data(mem_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
    endfunction

    // Memory model: combinational read, written on the write strobe.
    assign mem_data = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_addr[7:2]] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic [31:0] rd);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic lk);
        if (p == 1'b0) begin
            c_req = r; c_we = we; c_addr = a; c_wdata = wd; c_lock = lk;
        end else begin
            d_req = r; d_we = we; d_addr = a; d_wdata = wd; d_lock = lk;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    // Single access from an IDLE cycle; caller is at posedge+1.
    task automatic do_access(input vec_t v);
        int done_at = -1, addr_cyc = 0, we_cyc = 0, we_ok = 0;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata, 1'b0);
        push_exp(v.port, v.exp_rdata);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_addr == v.addr) addr_cyc++;
            if (mem_write_en) begin
                we_cyc++;
                if (mem_write_data == v.wdata) we_ok++;
            end
            if (v.port ? d_done : c_done) begin
                done_at = n;
                break;
            end
        end
        check("done_latency", 64'(done_at), 64'(LAT + 1));
        check("addr_cycles", 64'(addr_cyc), 64'(LAT));
        check("we_cycles", 64'(we_cyc), 64'(v.we));
        check("we_data", 64'(we_ok), 64'(v.we));
        @(posedge clk); #1;
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        if (v.we) ref_mem[v.addr[7:2]] = v.wdata;
    endtask

    // Scoreboard and exclusivity monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (c_gnt || d_gnt) check("gnt_excl", 64'(c_gnt & d_gnt), 64'd0);
            if (c_done || d_done) begin
                check("done_excl", 64'(c_done & d_done), 64'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: c_done=%0b d_done=%0b, none expected", c_done, d_done);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_port", 64'(d_done), 64'(mon_e.port));
                    check("sb_rdata", 64'(d_done ? d_rdata : c_rdata), 64'(mon_e.rdata));
                end
            end
        end
    end

    initial begin
        int cdn, dseen, ndone, cyc, prev_done;
        logic switched;

        vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vt[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
        vt[3] = '{1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 32'hDEADBEEF};
        vt[4] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hCAFEF00D};
        vt[5] = '{1'b1, 1'b0, 32'h14, 32'h0,        32'hA5000005};
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 64'({c_gnt, d_gnt, c_done, d_done, busy, mem_write_en}), 64'd0);
        check("rst_mem", 64'({mem_addr, mem_write_data}), 64'd0);
        check("rst_rdata", 64'({c_rdata, d_rdata}), 64'd0);
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 6; i++) do_access(vt[i]);

        // Reset while C is in BUSY: everything clears, no done, then re-grant.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_gnt", 64'(c_gnt), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("inflight_rst_ctrl", 64'({c_gnt, d_gnt, c_done, d_done, busy, mem_write_en}), 64'd0);
        check("inflight_rst_addr", 64'(mem_addr), 64'd0);
        check("inflight_rst_rdata", 64'(c_rdata), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        push_exp(1'b0, ref_mem[4]);
        @(negedge clk);
        check("regrant_idle", 64'(c_gnt), 64'd0);
        @(negedge clk);
        check("regrant_gnt", 64'(c_gnt), 64'd1);
        cyc = 0;
        while (!c_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("regrant_done", 64'(c_done), 64'd1);
        @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Both ports requesting continuously: C, D, C, D at L+2 spacing.
        pulse_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h1C, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, ref_mem[6]);
            push_exp(1'b1, ref_mem[7]);
        end
        ndone = 0;
        prev_done = -1;
        for (int n = 0; n < 60 && ndone < 4; n++) begin
            @(negedge clk);
            if (c_done || d_done) begin
                if (prev_done >= 0) check("rr_spacing", 64'(n - prev_done), 64'(LAT + 2));
                prev_done = n;
                ndone++;
            end
        end
        check("rr_count", 64'(ndone), 64'd4);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Request dropped mid-BUSY still completes with exactly one done.
        drive(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        push_exp(1'b0, ref_mem[9]);
        @(negedge clk);
        @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (c_done) ndone++;
        end
        check("drop_done_count", 64'(ndone), 64'd1);

        // Locked C read then unlocked C write while D waits.
        pulse_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h2C, 32'h0, 1'b0);
`ifdef MEM_ARB_LOCK_EN
        push_exp(1'b0, ref_mem[10]);
        push_exp(1'b0, ref_mem[10]);
        push_exp(1'b1, ref_mem[11]);
`else
        push_exp(1'b0, ref_mem[10]);
        push_exp(1'b1, ref_mem[11]);
        push_exp(1'b0, ref_mem[10]);
`endif
        ref_mem[10] = 32'h5555AAAA;
        cdn = 0;
        dseen = 0;
        switched = 1'b0;
        for (int n = 0; n < 60 && !(cdn == 2 && dseen == 1); n++) begin
            @(negedge clk);
            if (c_done) cdn++;
            if (d_done) dseen = 1;
            @(posedge clk); #1;
            if (cdn == 1 && !switched) begin
                drive(1'b0, 1'b1, 1'b1, 32'h28, 32'h5555AAAA, 1'b0);
                switched = 1'b1;
            end
            if (cdn == 2) c_req = 1'b0;
            if (dseen == 1) d_req = 1'b0;
        end
        check("lock_c_dones", 64'(cdn), 64'd2);
        check("lock_d_done", 64'(dseen), 64'd1);
        check("lock_mem_write", 64'(mem[10]), 64'h5555AAAA);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between two requesters: port C (core decoder: fetch and load/store) and port D (debug/program loader).
- Sits between the decoder's memory interface and the memory model.
- Serialises accesses, applies round-robin priority, counts the memory's fixed read latency and returns a registered read word with a one-cycle done pulse.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 1, cycles the memory needs from address valid to mem_data valid (legal range 1..15)
RESET_PRIO, 0, port favoured after reset (0 = C, 1 = D)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  port C request; held with c_we/c_addr/c_wdata stable until c_done
c_we  in  1  port C write (1) / read (0)
c_addr  in  ADDR_W  port C byte address
c_wdata  in  DATA_W  port C write data
c_lock  in  1  port C keep ownership after this access (see Optional Feature)
c_gnt  out  1  port C currently owns the memory
c_done  out  1  one-cycle pulse: port C access complete
c_rdata  out  DATA_W  port C read data, valid while c_done=1, held until the next C completion
d_req, d_we, d_addr, d_wdata, d_lock, d_gnt, d_done, d_rdata: same as port C, for port D
mem_addr  out  ADDR_W  memory address
mem_write_en  out  1  memory write strobe
mem_write_data  out  DATA_W  memory write data
mem_data  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, rdata registers 0, last-granted pointer = !RESET_PRIO, lock owner cleared. An in-flight access is abandoned; no done pulse is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port not granted last.
  - On grant: latch we/addr/wdata/owner, set cnt=MEM_LATENCY, assert gnt for the owner, go to BUSY.
- BUSY:
  - mem_addr and mem_write_data are driven from the latched values; they are 0 in IDLE and DONE.
  - mem_write_en=1 only in the first BUSY cycle, for writes.
  - cnt decrements each cycle.
  - When cnt==1: capture mem_data into the owner's rdata (reads only; writes leave rdata unchanged), then go to DONE.
- DONE: pulse the owner's done for one cycle, deassert gnt, update the last-granted pointer, go to IDLE.
- Latency: request seen in IDLE at cycle 0 gives done at cycle MEM_LATENCY+1. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Dropping req during BUSY does not cancel the access; done still pulses. A request change without done is a protocol error and is ignored.
- A request arriving during BUSY/DONE waits; it is arbitrated in the next IDLE cycle.
- gnt is never asserted for both ports in the same cycle; at most one done per cycle.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - If the owner has lock=1 at grant time, the lock owner is recorded.
  - In following IDLE cycles only the lock owner may be granted; the other port waits even if the pointer favours it.
  - The lock clears in DONE of an access granted with lock=0.
  - Purpose: atomic read-modify-write for sb/sh.
- Not defined: lock inputs are ignored; pure round-robin.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), port ID constants PORT_C=0 / PORT_D=1, MEM_LATENCY range limits.
- Sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last, lock_valid, lock_owner -> grant_id, grant_valid).

Test Plan:
- Reset with c_req=1 in flight (MEM_LATENCY=3, reset pulsed low in BUSY) -> all outputs 0 within the same cycle; no c_done; after release, C is re-granted from IDLE.
- Single C read, addr 0x10, mem_data=0xDEADBEEF, MEM_LATENCY=2 -> mem_addr=0x10 for 2 cycles; c_done at cycle 3; c_rdata=0xDEADBEEF.
- Single D write, addr 0x20, wdata 0x12345678 -> mem_write_en=1 for exactly one cycle with mem_write_data=0x12345678; d_done after MEM_LATENCY+1; d_rdata unchanged.
- Both ports requesting continuously after reset, RESET_PRIO=0 -> grants alternate C, D, C, D; never both gnt high.
- C drops c_req mid-BUSY -> access completes, c_done pulses once.
- With MEM_ARB_LOCK_EN: C read with c_lock=1, then C write with c_lock=0, while D requests throughout -> D granted only after the C write's DONE. Without the macro: D granted between the two C accesses.
